// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: prefix codes, event width, event struct, decoder state enum.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam int         PS2_EVT_W   = 10;

  // One key event as stored in the FIFO; ext is the MSB.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } dec_state_t;

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key-event stream between the receiver and its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds evt_ready low to stall; producer holds the head.
// Signals: evt_valid, evt_ready, evt_code[7:0], evt_ext, evt_brk.
interface ps2_key_rx_if;

  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_brk,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_brk,
    output evt_ready
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO for key events with sticky overflow flag.
// Latency: written word visible at pop_dat the cycle after push.
// Backpressure: push on full without a same-cycle pop is dropped and sets ovf.
// Ports: clk, rst, push/push_dat, pop/pop_dat, full, empty, ovf, ovf_clr.
module ps2_evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  input  logic         ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= push_dat;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop_ok) rptr <= rptr + (AW+1)'(1);
      // A new drop wins over a same-cycle clear.
      if (push && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: filters the pins, deframes bytes, decodes E0/F0 into events.
// Latency: evt_valid rises 2 clk after the stop-bit fall cycle into an empty FIFO.
// Backpressure: evt_ready low holds events in the FIFO; on full new events drop, ovf sets.
// Ports: clk, rst, ps2k_clk, ps2k_data, evt (master), parity_err, frame_err, ovf, ovf_clr.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2k_clk,
  input  logic         ps2k_data,
  ps2_key_rx_if.master evt,
  output logic         parity_err,
  output logic         frame_err,
  output logic         ovf,
  input  logic         ovf_clr
);

  localparam logic [3:0]    FILT_MAX = 4'(FILTER_LEN - 1);
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [3:0]    filt_cnt;
  logic          fall;
  logic [3:0]    bitn;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] idle_cnt;
  logic          byte_stb;
  logic [7:0]    byte_q;
  logic          dec_clr;
  dec_state_t    st;
  logic          push_vld;
  ps2_evt_t      push_evt;
  ps2_evt_t      head;
  logic          fifo_full;
  logic          fifo_empty;

  // Synchroniser and glitch filter; the filtered clock follows the pin only
  // after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= ps2k_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2k_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  // Frame deserialiser with idle timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitn       <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      idle_cnt   <= '0;
      byte_stb   <= 1'b0;
      byte_q     <= '0;
      dec_clr    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_stb   <= 1'b0;
      dec_clr    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (bitn)
          4'd0: begin
            // A high start bit is a misaligned edge: stay put and resync.
            if (!dat_s2) bitn <= 4'd1;
          end
          4'd9: begin
            par_bit <= dat_s2;
            bitn    <= 4'd10;
          end
          4'd10: begin
            bitn <= 4'd0;
            if (!dat_s2) frame_err <= 1'b1;
            if (!(^{shreg, par_bit})) begin
              parity_err <= 1'b1;
              dec_clr    <= 1'b1;
            end
            if (dat_s2 && (^{shreg, par_bit})) begin
              byte_stb <= 1'b1;
              byte_q   <= shreg;
            end
          end
          default: begin
            // LSB arrives first, so after eight shifts it sits at bit 0.
            shreg <= {dat_s2, shreg[7:1]};
            bitn  <= bitn + 4'd1;
          end
        endcase
      end else if (bitn != 4'd0) begin
        if (idle_cnt == TO_MAX) begin
          bitn      <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
          dec_clr   <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

  // Prefix decoder state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= S_IDLE;
    end else if (dec_clr) begin
      st <= S_IDLE;
    end else if (byte_stb) begin
      case (st)
        S_IDLE: begin
          if (byte_q == PS2_PFX_EXT)      st <= S_E0;
          else if (byte_q == PS2_PFX_BRK) st <= S_F0;
        end
        S_E0: begin
          if (byte_q == PS2_PFX_BRK)      st <= S_E0F0;
          else if (byte_q != PS2_PFX_EXT) st <= S_IDLE;
        end
        S_F0:    st <= S_IDLE;
        S_E0F0:  st <= S_IDLE;
      endcase
    end
  end

  // Event formed from the current state and the new byte; after a break
  // prefix every byte, including E0/F0, is taken as the key code.
  always_comb begin
    push_vld = 1'b0;
    push_evt = '0;
    if (byte_stb) begin
      push_evt.code = byte_q;
      case (st)
        S_IDLE: push_vld = (byte_q != PS2_PFX_EXT) && (byte_q != PS2_PFX_BRK);
        S_E0: begin
          push_vld     = (byte_q != PS2_PFX_EXT) && (byte_q != PS2_PFX_BRK);
          push_evt.ext = 1'b1;
        end
        S_F0: begin
          push_vld     = 1'b1;
          push_evt.brk = 1'b1;
        end
        S_E0F0: begin
          push_vld     = 1'b1;
          push_evt.ext = 1'b1;
          push_evt.brk = 1'b1;
        end
      endcase
    end
  end

  ps2_evt_fifo #(
    .W     (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_vld),
    .push_dat (push_evt),
    .pop      (evt.evt_ready),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_code  = head.code;
  assign evt.evt_ext   = head.ext;
  assign evt.evt_brk   = head.brk;

  a_full_not_empty: assert property (@(posedge clk) disable iff (!rst)
    fifo_full |-> !fifo_empty);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: drives PS/2 frames, predicts events with
// a prefix-flag model and a queue, and checks every head the DUT presents.
module tb_ps2_key_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int FIFO_DEPTH  = 8;
  localparam int HP          = 20;  // PS/2 half period in clk cycles
  // Pin fall to evt_valid: 2 sync + FILTER_LEN filter + byte strobe + FIFO write.
  localparam int LAT         = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2k_clk = 1'b1;
  logic ps2k_data = 1'b1;
  logic ovf_clr = 1'b0;
  logic parity_err, frame_err, ovf;

  ps2_key_rx_if evt_if();

  ps2_key_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2k_clk   (ps2k_clk),
    .ps2k_data  (ps2k_data),
    .evt        (evt_if),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: pending prefix flags plus the queue of expected events.
  ps2_evt_t model_q[$];
  logic pend_ext = 1'b0;
  logic pend_brk = 1'b0;
  logic exp_ovf = 1'b0;

  int pe_cnt = 0, fe_cnt = 0, both_cnt = 0, vcyc = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic mon_en = 1'b0;
  logic prev_vld = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input ps2_evt_t e);
    if (model_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
    else model_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    ps2_evt_t e;
    if (!pend_brk && b == 8'hE0) begin
      pend_ext = 1'b1;
    end else if (!pend_brk && b == 8'hF0) begin
      pend_brk = 1'b1;
    end else begin
      e.ext  = pend_ext;
      e.brk  = pend_brk;
      e.code = b;
      model_push(e);
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end
  endfunction

  function automatic void model_abort();
    pend_ext = 1'b0;
    pend_brk = 1'b0;
  endfunction

  function automatic int mlast();
    return 32'(model_q[model_q.size()-1]);
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      ps2k_data = f[i];
      repeat (HP/2) tick();
      ps2k_clk = 1'b0;
      if (i == 10) fall_cyc = cyc;
      repeat (HP) tick();
      ps2k_clk = 1'b1;
      repeat (HP/2) tick();
    end
    ps2k_data = 1'b1;
    repeat (HP) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (model_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_drained"}, model_q.size(), 0);
  endtask

  // Compare process: every valid head must match the model's front entry.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        pe_cnt   += 32'(parity_err);
        fe_cnt   += 32'(frame_err);
        both_cnt += 32'(parity_err & frame_err);
        if (evt_if.evt_valid) begin
          vcyc++;
          if (!prev_vld) rise_cyc = cyc;
          check("evt_expected", 32'(model_q.size() > 0), 1);
          if (model_q.size() > 0) begin
            check("evt_code", 32'(evt_if.evt_code), 32'(model_q[0].code));
            check("evt_ext",  32'(evt_if.evt_ext),  32'(model_q[0].ext));
            check("evt_brk",  32'(evt_if.evt_brk),  32'(model_q[0].brk));
            if (evt_if.evt_ready) void'(model_q.pop_front());
          end
        end
        prev_vld = evt_if.evt_valid;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [7:0] ovf_codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                                 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};

  initial begin
    int v0, p0, f0, b0, nbad;
    logic rdone;
    evt_if.evt_ready = 1'b1;
    repeat (4) tick();
    check("rst_valid", 32'(evt_if.evt_valid), 0);
    check("rst_code",  32'(evt_if.evt_code), 0);
    check("rst_ext_brk", 32'({evt_if.evt_ext, evt_if.evt_brk}), 0);
    check("rst_errs",  32'({parity_err, frame_err}), 0);
    check("rst_ovf",   32'(ovf), 0);
    rst = 1'b1;
    repeat (5) tick();
    mon_en = 1'b1;

    // Single make code, also pins latency and one-cycle valid.
    model_byte(8'h1C);
    check("model_1c", mlast(), 32'h01C);
    v0 = vcyc;
    send_byte(8'h1C, 1'b0, 1'b0);
    wait_drain("t1");
    check("t1_valid_cycles", vcyc - v0, 1);
    check("t1_latency", rise_cyc - fall_cyc, LAT);

    // Break.
    model_byte(8'hF0);
    model_byte(8'h1C);
    check("model_f0_1c", mlast(), 32'h11C);
    v0 = vcyc;
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);
    wait_drain("t2");
    check("t2_valid_cycles", vcyc - v0, 1);

    // Extended make and break.
    model_byte(8'hE0);
    model_byte(8'h75);
    check("model_e0_75", mlast(), 32'h275);
    model_byte(8'hE0);
    model_byte(8'hF0);
    model_byte(8'h75);
    check("model_e0f0_75", mlast(), 32'h375);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);
    wait_drain("t3");

    // Parity error after a pending E0: prefix dropped, no event.
    model_byte(8'hE0);
    model_abort();
    p0 = pe_cnt; f0 = fe_cnt; v0 = vcyc;
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b0);
    check("t4_parity_pulse", pe_cnt - p0, 1);
    check("t4_no_frame_err", fe_cnt - f0, 0);
    check("t4_no_event", vcyc - v0, 0);
    model_byte(8'hF0);
    model_byte(8'h1C);
    check("model_after_perr", mlast(), 32'h11C);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);
    wait_drain("t4");

    // Bad stop bit alone, then both errors together.
    p0 = pe_cnt; f0 = fe_cnt; b0 = both_cnt; v0 = vcyc;
    send_byte(8'h33, 1'b0, 1'b1);
    check("t5_stop_frame_err", fe_cnt - f0, 1);
    check("t5_stop_no_perr", pe_cnt - p0, 0);
    model_abort();
    send_byte(8'h33, 1'b1, 1'b1);
    check("t5_both_same_cycle", both_cnt - b0, 1);
    check("t5_both_perr", pe_cnt - p0, 1);
    check("t5_no_event", vcyc - v0, 0);

    // Timeout on a partial frame discards the pending E0 too.
    model_byte(8'hE0);
    send_byte(8'hE0, 1'b0, 1'b0);
    p0 = pe_cnt; f0 = fe_cnt; v0 = vcyc;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 5);
    repeat (TIMEOUT_CYC + 10) tick();
    model_abort();
    check("t6_timeout_pulse", fe_cnt - f0, 1);
    check("t6_no_perr", pe_cnt - p0, 0);
    check("t6_no_event", vcyc - v0, 0);
    model_byte(8'h29);
    check("model_after_timeout", mlast(), 32'h029);
    send_byte(8'h29, 1'b0, 1'b0);
    wait_drain("t6");

    // Overflow: hold the consumer off for FIFO_DEPTH+2 events.
    evt_if.evt_ready = 1'b0;
    foreach (ovf_codes[i]) begin
      model_byte(ovf_codes[i]);
      send_byte(ovf_codes[i], 1'b0, 1'b0);
    end
    check("ovf_model_depth", model_q.size(), FIFO_DEPTH);
    check("ovf_set", 32'(ovf), 32'(exp_ovf));
    check("ovf_head_code", 32'(evt_if.evt_code), 32'h15);
    tick();
    evt_if.evt_ready = 1'b1;
    wait_drain("t7");
    check("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    tick();
    check("ovf_cleared", 32'(ovf), 32'(exp_ovf));

    // Randomised traffic with a randomly stalling consumer.
    nbad = 0;
    p0 = pe_cnt;
    rdone = 1'b0;
    fork
      begin
        while (!rdone) begin
          tick();
          evt_if.evt_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          int r;
          logic [7:0] b;
          logic bad;
          r = $urandom_range(0, 7);
          b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
          bad = ($urandom_range(0, 7) == 0);
          if (bad) begin
            model_abort();
            nbad++;
          end else begin
            model_byte(b);
          end
          send_byte(b, bad, 1'b0);
        end
        rdone = 1'b1;
      end
    join
    evt_if.evt_ready = 1'b1;
    wait_drain("rand");
    check("rand_parity_errs", pe_cnt - p0, nbad);
    check("rand_no_ovf", 32'(ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Parametrised PS/2 keyboard receiver; successor to the simple single-byte scanner.
- Filters and synchronises the PS/2 clock, deserialises 11-bit frames, and checks start, odd parity and stop bits.
- Decodes E0/F0 prefixes into make/break events for normal and extended keys, and buffers events in a FIFO with a valid/ready interface.
- Sits between the PS/2 pins and the system event consumer (ASCII mapper, game logic).

Parameters:
- FILTER_LEN, 4: filtered PS/2 clock changes only after FILTER_LEN consecutive equal synchronised samples (1..15).
- TIMEOUT_CYC, 50000: clk cycles without a falling edge before a partial frame is aborted (about 1 ms at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ps2k_clk  in  1  raw PS/2 clock pin
- ps2k_data  in  1  raw PS/2 data pin
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head; pop on evt_valid & evt_ready
- evt_code  out  8  scan code of head event
- evt_ext  out  1  head event was E0-prefixed
- evt_brk  out  1  head event is a break (release)
- parity_err  out  1  one-cycle pulse on odd-parity failure
- frame_err  out  1  one-cycle pulse on bad stop bit or timeout abort
- ovf  out  1  sticky: an event was dropped on full FIFO; cleared by ovf_clr
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; evt_code 8'h00.
  - FIFO empty, bit counter 0, decoder in IDLE.
  - Synchroniser and filter registers load 1 (bus idle high).
  - A reset in mid-frame discards the partial byte and any pending prefix.
- Clock conditioning:
  - 2-flop synchroniser on both pins.
  - Saturating filter counter on clock; filtered clock toggles when the count reaches FILTER_LEN.
  - fall = filtered clock 1->0, a single-cycle strobe.
  - Data is sampled from the synchronised data at the fall cycle.
- Frame counter bitn, 0..10, advances on each fall:
  - bitn 0: data must be 0 (start bit). If it is 1, ignore it and stay at 0 (resync); no error.
  - bitn 1..8: shift data into bit bitn-1 (LSB first).
  - bitn 9: capture parity.
  - bitn 10: check stop bit and parity; return to 0.
    - Stop bit 0: frame_err pulse, byte dropped.
    - Parity wrong (XOR of data bits and parity must be 1): parity_err pulse, byte dropped, decoder forced to IDLE.
    - Both bad: both pulse in the same cycle.
    - Good frame: byte_stb pulses the cycle after the stop-bit fall.
- Timeout:
  - Idle counter clears on every fall and counts only while bitn != 0.
  - Reaching TIMEOUT_CYC: bitn := 0, frame_err pulse, decoder forced to IDLE.
- Decoder FSM, states IDLE, E0, F0, E0F0, advances on byte_stb:
  - IDLE: E0 -> E0; F0 -> F0; other -> push {ext=0, brk=0, code}.
  - E0: F0 -> E0F0; E0 -> E0; other -> push {1, 0, code}, go IDLE.
  - F0: push {0, 1, code}, go IDLE (code F0/E0 also pushed literally).
  - E0F0: push {1, 1, code}, go IDLE.
- FIFO: first-word fall-through; evt_* always show the head.
  - Latency: evt_valid rises 2 clk after the stop-bit fall cycle when the FIFO is empty.
  - Push on full without a same-cycle pop: event dropped, ovf set.
  - Push and pop on full in the same cycle: both succeed, no ovf.
  - Pop on empty: ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - ovf_clr and a new overflow in the same cycle: ovf stays 1.
- Outputs are registered.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_EVT_W=10.
  - Event typedef {ext, brk, code[7:0]}.
  - Decoder state enum.
- Sub-module ps2_evt_fifo: parametrised FWFT FIFO with width PS2_EVT_W and depth FIFO_DEPTH, with push, pop, full, empty and ovf outputs.

Test Plan:
- Frame 1C with good parity, evt_ready=1 -> one event: code=1C, ext=0, brk=0; evt_valid high for 1 cycle.
- Frames F0,1C -> single event: code=1C, brk=1, ext=0; no event for F0.
- Frames E0,75 then E0,F0,75 -> events {75, ext=1, brk=0} then {75, ext=1, brk=1}.
- Frame 1C with parity bit inverted, then frames F0,1C -> parity_err pulse, no event for the bad frame; next event {1C, brk=1}.
- 5 bits of a frame, then silence for TIMEOUT_CYC+10 cycles, then good frame 29 -> frame_err pulse once; event {29, 0, 0}; no garbage event.
- evt_ready=0, FIFO_DEPTH+2 make frames 15,1D,24,... -> first FIFO_DEPTH events retained in order, ovf=1. Then evt_ready=1 drains them in order; ovf_clr clears ovf.
